// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller.
//   DMEM_WAIT_DEFAULT : default number of access wait states (legal 1..15)
//   DMEM_WORD_W       : data word width
//   dmem_state_t      : controller FSM states
//   dmem_op_t         : operation latched when a request is accepted
package dmem_ctrl_pkg;

    localparam int unsigned DMEM_WAIT_DEFAULT = 2;
    localparam int unsigned DMEM_WORD_W       = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } dmem_state_t;

    typedef struct packed {
        logic rd;   // read-only request: loads dm_out on completion
        logic wr;   // write request (also set when read+write collide)
        logic err;  // read and write were both requested
    } dmem_op_t;

endpackage

// File: rtl/dmem_ctrl_array.sv
// Single-port data storage, 2^DEPTH_LOG2 x 16 bits, no reset.
// Ports:
//   clk   - clock
//   we    - write enable: mem[addr] <= wdata on the rising edge
//   re    - read enable: rdata <= mem[addr] on the rising edge
//   addr  - word address
//   wdata - write data
//   rdata - registered read data (holds when re is low)
module dmem_array
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic                   re,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic [DMEM_WORD_W-1:0] wdata,
    output logic [DMEM_WORD_W-1:0] rdata
);

    logic [DMEM_WORD_W-1:0] mem [0:(2**DEPTH_LOG2)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller for the MEM pipeline stage. Accepts one read or
// write, stalls the pipeline for WAIT+1 cycles, completes in DONE.
// Ports:
//   clk     - clock, rising edge
//   rst_n   - asynchronous active-low reset
//   dm_re   - read request
//   dm_we   - write request
//   dm_addr - word address (upper bits above DEPTH_LOG2 ignored)
//   dm_in   - write data
//   dm_out  - read data, valid in DONE and held until the next read
//   stall   - freeze pipeline registers while high
//   dm_err  - one-cycle pulse in DONE when read and write collided
module dmem_ctrl
    import dmem_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH_LOG2 = 10,
    parameter int unsigned WAIT       = DMEM_WAIT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dm_re,
    input  logic        dm_we,
    input  logic [15:0] dm_addr,
    input  logic [15:0] dm_in,
    output logic [15:0] dm_out,
    output logic        stall,
    output logic        dm_err
);

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    dmem_state_t           state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic [DEPTH_LOG2-1:0] addr_q;
    logic [15:0]           data_q;
    dmem_op_t              op_q;
    logic [15:0]           out_q;
    logic [15:0]           rd_data;
    logic                  req;
    logic                  accept;
    logic                  access;
    logic                  unused_addr_hi;

    assign req            = dm_re | dm_we;
    assign unused_addr_hi = ^dm_addr[15:DEPTH_LOG2];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        access   = 1'b0;
        case (state)
            IDLE: begin
                if (req) begin
                    accept   = 1'b1;
                    cnt_nx   = WAIT_CNT;
                    state_nx = BUSY;
                end
            end
            BUSY: begin
                cnt_nx = cnt - 4'd1;
                if (cnt == 4'd1) begin
                    access   = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            data_q <= '0;
            op_q   <= '0;
            out_q  <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            if (accept) begin
                addr_q  <= dm_addr[DEPTH_LOG2-1:0];
                data_q  <= dm_in;
                op_q.rd <= dm_re & ~dm_we;
                op_q.wr <= dm_we;
                op_q.err <= dm_re & dm_we;
            end
            if (state == DONE && op_q.rd) begin
                out_q <= rd_data;
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_array (
        .clk  (clk),
        .we   (access & op_q.wr),
        .re   (access & op_q.rd),
        .addr (addr_q),
        .wdata(data_q),
        .rdata(rd_data)
    );

    // The array's read register is loaded on the access edge, so in a read's
    // DONE cycle it is forwarded directly; out_q captures it for holding.
    assign dm_out = (state == DONE && op_q.rd) ? rd_data : out_q;

    // Gated with rst_n so a request held during reset never shows a stall.
    assign stall  = rst_n & (((state == IDLE) & req) | (state == BUSY));
    assign dm_err = (state == DONE) & op_q.err;

endmodule

// File: tb/tb_dmem_ctrl.sv
module tb_dmem_ctrl;

    localparam int W0 = 2;
    localparam int W1 = 1;

    logic        clk;
    logic        rst_n;
    logic        re0, we0, re1, we1;
    logic [15:0] a0, d0, a1, d1;
    logic [15:0] out0, out1;
    logic        st0, st1, err0, err1;

    int n_cmp;
    int n_bad;
    int cyc;

    dmem_ctrl #(.DEPTH_LOG2(10), .WAIT(W0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .dm_re(re0), .dm_we(we0), .dm_addr(a0),
        .dm_in(d0), .dm_out(out0), .stall(st0), .dm_err(err0)
    );

    dmem_ctrl #(.DEPTH_LOG2(10), .WAIT(W1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .dm_re(re1), .dm_we(we1), .dm_addr(a1),
        .dm_in(d1), .dm_out(out1), .stall(st1), .dm_err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Each transaction: accepted at cycle T, completes (DONE) at T+W+1.
    bit          pend [2];
    int          acc  [2];
    bit          lre  [2];
    bit          lwe  [2];
    int          la   [2];
    logic [15:0] ld   [2];
    logic [15:0] eout [2];
    logic [15:0] mm   [int];

    initial begin
        for (int k = 0; k < 2; k++) begin
            pend[k] = 0;
            eout[k] = '0;
        end
    end

    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            int          w;
            logic        m_re, m_we, a_st, a_err;
            logic [15:0] m_a, m_d, a_out;
            logic        x_st, x_err;
            w     = (k == 0) ? W0 : W1;
            m_re  = (k == 0) ? re0 : re1;
            m_we  = (k == 0) ? we0 : we1;
            m_a   = (k == 0) ? a0 : a1;
            m_d   = (k == 0) ? d0 : d1;
            a_st  = (k == 0) ? st0 : st1;
            a_err = (k == 0) ? err0 : err1;
            a_out = (k == 0) ? out0 : out1;
            x_st  = 1'b0;
            x_err = 1'b0;
            if (!rst_n) begin
                pend[k] = 0;
                eout[k] = '0;
            end else if (pend[k] && cyc == acc[k] + w + 1) begin
                x_err = lre[k] & lwe[k];
                if (lwe[k]) begin
                    mm[k * 4096 + la[k]] = ld[k];
                end else if (mm.exists(k * 4096 + la[k])) begin
                    eout[k] = mm[k * 4096 + la[k]];
                end else begin
                    eout[k] = 'x;
                end
                pend[k] = 0;
            end else if (pend[k]) begin
                x_st = 1'b1;
            end else if (m_re | m_we) begin
                pend[k] = 1;
                acc[k]  = cyc;
                lre[k]  = m_re;
                lwe[k]  = m_we;
                la[k]   = int'(m_a) % 1024;
                ld[k]   = m_d;
                x_st    = 1'b1;
            end
            chk($sformatf("model_stall%0d", k), {31'd0, a_st}, {31'd0, x_st});
            chk($sformatf("model_err%0d", k), {31'd0, a_err}, {31'd0, x_err});
            if (!$isunknown(eout[k])) begin
                chk($sformatf("model_out%0d", k), {16'd0, a_out}, {16'd0, eout[k]});
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic set(input int k, input logic r, input logic w,
                       input logic [15:0] a, input logic [15:0] d);
        if (k == 0) begin
            re0 = r; we0 = w; a0 = a; d0 = d;
        end else begin
            re1 = r; we1 = w; a1 = a; d1 = d;
        end
    endtask

    function automatic logic stall_of(input int k);
        return (k == 0) ? st0 : st1;
    endfunction

    // Issue one request, count stall cycles, sample outputs in the DONE cycle.
    task automatic xact(input int k, input logic r, input logic w,
                        input logic [15:0] a, input logic [15:0] d, input bit drop,
                        output int nstall, output logic [15:0] out, output logic err);
        bit done;
        @(posedge clk);
        #1 set(k, r, w, a, d);
        nstall = 0;
        done   = 0;
        out    = 'x;
        err    = 1'bx;
        for (int i = 0; i < 40 && !done; i++) begin
            @(negedge clk);
            if (stall_of(k)) begin
                nstall++;
                if (drop && nstall == 1) begin
                    @(posedge clk);
                    #1 set(k, 1'b0, 1'b0, a ^ 16'h0040, 16'hFFFF);
                end
            end else begin
                done = 1;
                out  = (k == 0) ? out0 : out1;
                err  = (k == 0) ? err0 : err1;
            end
        end
        if (!done) chk("xact_timeout", 32'd1, 32'd0);
        @(posedge clk);
        #1 set(k, 1'b0, 1'b0, 16'h0000, 16'h0000);
    endtask

    // ---------------- directed test ----------------
    initial begin
        int          ns;
        logic [15:0] o;
        logic        e;
        logic [8:0]  pat;
        logic [15:0] mid;

        n_cmp = 0;
        n_bad = 0;
        rst_n = 1'b1;
        set(0, 1'b0, 1'b0, 16'h0, 16'h0);
        set(1, 1'b0, 1'b0, 16'h0, 16'h0);
        #2 rst_n = 1'b0;
        // Request held during reset must not raise stall.
        set(0, 1'b1, 1'b1, 16'h0010, 16'h9999);
        #10;
        chk("rst_stall", {31'd0, st0}, 32'd0);
        chk("rst_out", {16'd0, out0}, 32'h0000);
        chk("rst_err", {31'd0, err0}, 32'd0);
        @(posedge clk);
        #1 set(0, 1'b0, 1'b0, 16'h0, 16'h0);
        rst_n = 1'b1;

        // Write then read back, stall 3 cycles each.
        xact(0, 1'b0, 1'b1, 16'h0010, 16'hBEEF, 0, ns, o, e);
        chk("wr_stall_cycles", ns, 3);
        xact(0, 1'b1, 1'b0, 16'h0010, 16'h0000, 0, ns, o, e);
        chk("rd_stall_cycles", ns, 3);
        chk("rd_beef", {16'd0, o}, 32'hBEEF);

        // Aliasing above DEPTH_LOG2.
        xact(0, 1'b1, 1'b0, 16'h0410, 16'h0000, 0, ns, o, e);
        chk("alias_beef", {16'd0, o}, 32'hBEEF);

        // Read+write collision: write wins, dm_out unchanged, err pulse.
        xact(0, 1'b1, 1'b1, 16'h0020, 16'h1234, 0, ns, o, e);
        chk("both_err", {31'd0, e}, 32'd1);
        chk("both_out_kept", {16'd0, o}, 32'hBEEF);
        xact(0, 1'b1, 1'b0, 16'h0020, 16'h0000, 0, ns, o, e);
        chk("both_readback", {16'd0, o}, 32'h1234);
        chk("rd_err_clear", {31'd0, e}, 32'd0);

        // Inputs dropped/changed during BUSY.
        xact(0, 1'b0, 1'b1, 16'h0050, 16'hCAFE, 0, ns, o, e);
        xact(0, 1'b1, 1'b0, 16'h0050, 16'h0000, 1, ns, o, e);
        chk("drop_stall_cycles", ns, 3);
        chk("drop_data", {16'd0, o}, 32'hCAFE);

        // Reset during BUSY discards the write.
        xact(0, 1'b0, 1'b1, 16'h0030, 16'h5555, 0, ns, o, e);
        @(posedge clk);
        #1 set(0, 1'b0, 1'b1, 16'h0030, 16'hAAAA);
        @(posedge clk);
        #1 chk("pre_rst_stall", {31'd0, st0}, 32'd1);
        #1 rst_n = 1'b0;
        set(0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1 chk("busy_rst_stall", {31'd0, st0}, 32'd0);
        chk("busy_rst_out", {16'd0, out0}, 32'h0000);
        @(posedge clk);
        #1 rst_n = 1'b1;
        xact(0, 1'b1, 1'b0, 16'h0030, 16'h0000, 0, ns, o, e);
        chk("rst_kept_old", {16'd0, o}, 32'h5555);

        // WAIT=1 instance: back-to-back write/read/write.
        xact(1, 1'b0, 1'b1, 16'h0100, 16'h2222, 0, ns, o, e);
        chk("w1_stall_cycles", ns, 2);
        @(posedge clk);
        pat = '0;
        mid = '0;
        for (int i = 0; i < 9; i++) begin
            #1;
            if (i == 0) set(1, 1'b0, 1'b1, 16'h0040, 16'h7777);
            if (i == 3) set(1, 1'b1, 1'b0, 16'h0040, 16'h0000);
            if (i == 6) set(1, 1'b0, 1'b1, 16'h0041, 16'h8888);
            @(negedge clk);
            pat[8 - i] = st1;
            if (i == 5) mid = out1;
            @(posedge clk);
        end
        #1 set(1, 1'b0, 1'b0, 16'h0, 16'h0);
        chk("b2b_stall_pattern", {23'd0, pat}, {23'd0, 9'b110110110});
        chk("b2b_read", {16'd0, mid}, 32'h7777);
        xact(1, 1'b1, 1'b0, 16'h0041, 16'h0000, 0, ns, o, e);
        chk("b2b_second_write", {16'd0, o}, 32'h8888);
        xact(1, 1'b1, 1'b0, 16'h0100, 16'h0000, 0, ns, o, e);
        chk("w1_readback", {16'd0, o}, 32'h2222);

        repeat (3) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
